// File: rtl/hex_scan_pkg.sv
// Shared types, ASCII constants and the nibble-to-character helper for the
// multiplexed hex display scan driver.
package hex_scan_pkg;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_PEND = 1'b1
    } state_t;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_A = 8'h41;

    // Uppercase only: the downstream segment decoder has no lowercase entries.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib <= 4'd9) begin
            return ASCII_0 + {4'h0, nib};
        end
        return ASCII_A + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/hex_scan_driver_scan_timer.sv
// Slot prescaler and digit index for the scan driver; exposes both current and
// next-state counter values so the parent can register outputs in lockstep.
module scan_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int PRE_W      = $clog2(SCAN_DIV),
    parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [PRE_W-1:0] pre_next_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [IDX_W-1:0] idx_next_o,
    output logic             tc_o,
    output logic             fb_o
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             tc;
    logic             fb;

    always_comb begin
        tc    = (pre_q == PRE_LAST);
        fb    = tc && (idx_q == IDX_LAST);
        pre_d = tc ? '0 : pre_q + 1'b1;
        idx_d = idx_q;
        if (tc) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_q <= '0;
            idx_q <= '0;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
        end
    end

    assign pre_next_o = pre_d;
    assign idx_o      = idx_q;
    assign idx_next_o = idx_d;
    assign tc_o       = tc;
    assign fb_o       = fb;

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed hex scan driver feeding an ASCII 7-segment decoder; new
// values are staged in a shadow register and only take effect at frame edges.
module hex_scan_driver
    import hex_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DEAD       = 500,
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic                    lz_blank_i,
    output logic [7:0]              char_o,
    output logic [NUM_DIGITS-1:0]   digit_sel_o,
    output logic [IDX_W-1:0]        digit_idx_o
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int VAL_W = 4 * NUM_DIGITS;

    logic [PRE_W-1:0]      pre_next;
    logic [IDX_W-1:0]      idx_next;
    logic                  tc;
    logic                  fb;
    logic                  dead;

    state_t                state_q, state_d;
    logic                  ready_q, ready_d;
    logic [VAL_W-1:0]      shadow_q, shadow_d;
    logic [VAL_W-1:0]      disp_q, disp_d;
    logic                  blank_q, blank_d;
    logic [7:0]            char_q, char_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [3:0]            cur_nib;
    logic                  upper_nz;

    scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .PRE_W      (PRE_W),
        .IDX_W      (IDX_W)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .pre_next_o (pre_next),
        .idx_o      (digit_idx_o),
        .idx_next_o (idx_next),
        .tc_o       (tc),
        .fb_o       (fb)
    );

    if (DEAD == 0) begin : g_no_dead
        assign dead = 1'b0;
    end else begin : g_dead
        assign dead = (pre_next < PRE_W'(DEAD));
    end

    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        shadow_d = shadow_q;
        disp_d   = disp_q;
        case (state_q)
            S_RUN: begin
                if (valid_i && ready_q) begin
                    shadow_d = value_i;
                    state_d  = S_PEND;
                    ready_d  = 1'b0;
                end
            end
            S_PEND: begin
                if (fb) begin
                    disp_d  = shadow_q;
                    state_d = S_RUN;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_RUN;
                ready_d = 1'b1;
            end
        endcase

        cur_nib  = 4'h0;
        upper_nz = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_next == IDX_W'(k)) begin
                cur_nib = disp_d[4*k +: 4];
            end
            if ((IDX_W'(k) >= idx_next) && (disp_d[4*k +: 4] != 4'h0)) begin
                upper_nz = 1'b1;
            end
        end

        // Blanking is decided once per slot so a mid-slot toggle cannot chop a digit.
        blank_d = blank_q;
        if (tc) begin
            blank_d = lz_blank_i && (idx_next != '0) && !upper_nz;
        end

        for (int k = 0; k < NUM_DIGITS; k++) begin
            sel_d[k] = (idx_next != IDX_W'(k));
        end
        if (dead || blank_d) begin
            sel_d = '1;
        end

        char_d = nibble_to_ascii(cur_nib);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_RUN;
            ready_q  <= 1'b1;
            shadow_q <= '0;
            disp_q   <= '0;
            blank_q  <= 1'b0;
            char_q   <= ASCII_0;
            sel_q    <= '1;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            blank_q  <= blank_d;
            char_q   <= char_d;
            sel_q    <= sel_d;
        end
    end

    assign ready_o     = ready_q;
    assign char_o      = char_q;
    assign digit_sel_o = sel_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Self-checking bench for hex_scan_driver: directed scenarios followed by random
// traffic, all compared every cycle against a frame-position reference model.
module tb_hex_scan_driver;

    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int DT    = 1;
    localparam int FRAME = ND * SD;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] value_i;
    logic        valid_i;
    logic        ready_o;
    logic        lz_blank_i;
    logic [7:0]  char_o;
    logic [3:0]  digit_sel_o;
    logic [1:0]  digit_idx_o;

    int          checks = 0;
    int          errors = 0;

    // Reference model state: edges since reset release, shown value, pending value.
    int          edge_n;
    logic [15:0] m_disp;
    logic [15:0] m_shadow;
    bit          m_pend;
    int          m_apply_at;
    bit          m_lz_slot;

    int          dead_cnt;
    logic [7:0]  exp_chars [4];
    logic [3:0]  exp_sels [4];

    hex_scan_driver #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .DEAD       (DT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .value_i     (value_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .lz_blank_i  (lz_blank_i),
        .char_o      (char_o),
        .digit_sel_o (digit_sel_o),
        .digit_idx_o (digit_idx_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] expAscii(input int nib);
        return (nib < 10) ? 8'(48 + nib) : 8'(55 + nib);
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    // Expected outputs follow purely from the position inside the frame.
    task automatic checkOutput();
        int         p;
        int         slot;
        int         w;
        int         upper;
        bit         blank;
        logic [7:0] ec;
        logic [3:0] es;
        p     = edge_n % FRAME;
        slot  = p / SD;
        w     = p % SD;
        upper = int'(m_disp >> (4 * slot));
        ec    = expAscii(upper & 15);
        blank = m_lz_slot && (slot != 0) && (upper == 0);
        es    = (w < DT || blank) ? 4'hF : ~(4'b0001 << slot);
        checkValue("char_o", char_o, ec);
        checkValue("digit_sel_o", digit_sel_o, es);
        checkValue("digit_idx_o", digit_idx_o, slot);
        checkValue("ready_o", ready_o, !m_pend);
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] val, input logic lz);
        valid_i    = v;
        value_i    = val;
        lz_blank_i = lz;
        @(posedge clk_i);
        edge_n++;
        if (v && !m_pend) begin
            m_shadow   = val;
            m_pend     = 1'b1;
            m_apply_at = (edge_n / FRAME + 1) * FRAME;
        end else if (m_pend && edge_n == m_apply_at) begin
            m_disp = m_shadow;
            m_pend = 1'b0;
        end
        if (edge_n % SD == 0) m_lz_slot = lz;
        #1;
        checkOutput();
    endtask

    task automatic modelReset();
        edge_n    = 0;
        m_disp    = 16'h0;
        m_shadow  = 16'h0;
        m_pend    = 1'b0;
        m_lz_slot = 1'b0;
    endtask

    // Asserts reset between clock edges, checks the immediate effect, then releases.
    task automatic doReset();
        #2;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        #1;
        modelReset();
        checkValue("rst_char", char_o, 8'h30);
        checkValue("rst_sel", digit_sel_o, 4'b1111);
        checkValue("rst_idx", digit_idx_o, 0);
        checkValue("rst_ready", ready_o, 1);
        repeat (2) @(posedge clk_i);
        #3;
        rst_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, edge %0d", edge_n);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i      = 1'b1;
        valid_i    = 1'b0;
        value_i    = 16'h0;
        lz_blank_i = 1'b0;
        exp_chars  = '{8'h46, 8'h33, 8'h41, 8'h31};
        exp_sels   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        modelReset();
        @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        $display("[TB] reset released, loading 1A3F");

        applyStimulus(1'b1, 16'h1A3F, 1'b0);
        checkValue("first_anode", digit_sel_o, 4'b1110);
        checkValue("ready_after_load", ready_o, 0);
        dead_cnt = 0;
        while (edge_n < 2 * FRAME - 1) begin
            applyStimulus(1'b0, 16'h0, 1'b0);
            if (edge_n == FRAME - 1) checkValue("ready_before_fb", ready_o, 0);
            if (edge_n == FRAME)     checkValue("ready_at_fb", ready_o, 1);
            if (edge_n >= FRAME && digit_sel_o == 4'hF) dead_cnt++;
            if (edge_n >= FRAME && edge_n % SD == DT) begin
                checkValue("frame_char", char_o, exp_chars[(edge_n - FRAME) / SD]);
                checkValue("frame_sel", digit_sel_o, exp_sels[(edge_n - FRAME) / SD]);
            end
        end
        checkValue("dead_cycles_per_frame", dead_cnt, 4);

        $display("[TB] reset during pending load at digit 2");
        applyStimulus(1'b0, 16'h0, 1'b0);
        applyStimulus(1'b1, 16'hBEEF, 1'b0);
        while (edge_n < 41) applyStimulus(1'b0, 16'h0, 1'b0);
        checkValue("pre_rst_idx", digit_idx_o, 2);
        doReset();

        $display("[TB] leading-zero blanking");
        applyStimulus(1'b1, 16'h0040, 1'b1);
        checkValue("anode_after_reset", digit_sel_o, 4'b1110);
        while (edge_n < 3 * FRAME - 1) begin
            applyStimulus(1'b0, 16'h0, 1'b1);
            if (edge_n == 17) checkValue("lz_d0_char", char_o, 8'h30);
            if (edge_n == 21) checkValue("lz_d1_sel", digit_sel_o, 4'b1101);
            if (edge_n == 21) checkValue("lz_d1_char", char_o, 8'h34);
            if (edge_n == 26) checkValue("lz_d2_sel", digit_sel_o, 4'b1111);
            if (edge_n == 30) checkValue("lz_d3_sel", digit_sel_o, 4'b1111);
        end
        applyStimulus(1'b1, 16'h0000, 1'b1);
        while (edge_n < 5 * FRAME - 1) begin
            applyStimulus(1'b0, 16'h0, 1'b1);
            if (edge_n == 65) checkValue("zero_d0_sel", digit_sel_o, 4'b1110);
            if (edge_n == 69) checkValue("zero_d1_sel", digit_sel_o, 4'b1111);
            if (edge_n == 69) checkValue("zero_d1_char", char_o, 8'h30);
        end

        $display("[TB] back-to-back offers");
        applyStimulus(1'b1, 16'h1111, 1'b0);
        checkValue("b2b_ready_low", ready_o, 0);
        while (edge_n < 6 * FRAME) applyStimulus(1'b1, 16'h2222, 1'b0);
        checkValue("b2b_ready_back", ready_o, 1);
        checkValue("b2b_first", char_o, 8'h31);
        applyStimulus(1'b1, 16'h2222, 1'b0);
        checkValue("b2b_second_taken", ready_o, 0);
        while (edge_n < 7 * FRAME - 1) applyStimulus(1'b1, 16'h2222, 1'b0);
        checkValue("b2b_old_kept", char_o, 8'h31);
        applyStimulus(1'b0, 16'h0, 1'b0);
        checkValue("b2b_second_shown", char_o, 8'h32);

        $display("[TB] handshake on frame boundary");
        while (edge_n % FRAME != FRAME - 1) applyStimulus(1'b0, 16'h0, 1'b0);
        applyStimulus(1'b1, 16'h5A5A, 1'b0);
        checkValue("fb_hs_no_change", char_o, 8'h32);
        repeat (FRAME - 1) applyStimulus(1'b0, 16'h0, 1'b0);
        checkValue("fb_hs_still_old", char_o, 8'h32);
        applyStimulus(1'b0, 16'h0, 1'b0);
        checkValue("fb_hs_applied", char_o, 8'h41);

        $display("[TB] random traffic");
        begin
            logic lz_r;
            lz_r = 1'b0;
            for (int i = 0; i < 320; i++) begin
                if ((edge_n + 1) % SD == 0) lz_r = 1'($urandom_range(0, 1));
                applyStimulus(($urandom_range(0, 3) == 0), 16'($urandom), lz_r);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
